// File: rtl/wbm_pkg.sv
// Shared types and widths for the Wishbone classic single-beat manager.
package wbm_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [0:0] {
    WBM_IDLE,
    WBM_BUS
  } wbm_state_e;

endpackage

// File: rtl/wbm_timeout_counter.sv
// Bus-cycle watchdog: counts no-ack BUS cycles.
// Fires on the edge that completes the limit-th cycle.
module wbm_timeout_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + Width'(1);
    end
  end

  // The count reaches the limit on this edge.
  assign expired = enable && (count_q == limit - Width'(1));

endmodule

// File: rtl/wishbone_manager.sv
// Wishbone classic single-beat manager bridging a valid/ready request port to the bus.
// Optional bus watchdog enabled by defining WBM_TIMEOUT_EN.
module wishbone_manager
  import wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                nrst,
  input  logic                cpu_req_valid,
  input  logic                cpu_req_we,
  input  logic [WB_ADR_W-1:0] cpu_req_adr,
  input  logic [WB_DAT_W-1:0] cpu_req_dat,
  input  logic [WB_SEL_W-1:0] cpu_req_sel,
  output logic                cpu_req_ready,
  output logic                cpu_rsp_valid,
  output logic [WB_DAT_W-1:0] cpu_rsp_dat,
  output logic                cpu_rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wbm_state_e          state_q, state_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  wbm_timeout_counter #(
    .Width(CntW)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (nrst),
    .clear  (state_q == WBM_IDLE),
    .enable ((state_q == WBM_BUS) && !wbm_ack_i),
    .limit  (CntW'(TIMEOUT_CYCLES)),
    .expired(timeout)
  );
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      WBM_IDLE: begin
        if (cpu_req_valid) begin
          we_d    = cpu_req_we;
          sel_d   = cpu_req_sel;
          adr_d   = cpu_req_adr;
          dat_d   = cpu_req_dat;
          state_d = WBM_BUS;
        end
      end
      WBM_BUS: begin
        // Ack takes priority over a coincident timeout.
        if (wbm_ack_i) begin
          state_d     = WBM_IDLE;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
        end else if (timeout) begin
          state_d     = WBM_IDLE;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = WBM_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge nrst) begin
    if (!nrst) begin
      state_q     <= WBM_IDLE;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // cyc/stb decode straight from state so an async reset drops them at once.
  assign cpu_req_ready = (state_q == WBM_IDLE);
  assign wbm_cyc_o     = (state_q == WBM_BUS);
  assign wbm_stb_o     = (state_q == WBM_BUS);
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_dat   = rsp_dat_q;
  assign cpu_rsp_err   = rsp_err_q;

endmodule

// File: doc/wishbone_manager.md
Name: wishbone_manager

Overview:
- Wishbone classic single-beat bus master: the initiator end of the interface that the chip wrapper and team wrappers expose as slaves.
- Team logic issues simple read/write requests on a valid/ready port. The block drives cyc/stb/we/sel/adr/dat until the slave acks, then returns a one-cycle response.
- Instantiated inside a team wrapper so a team project can reach shared Wishbone peripherals (SRAM, control registers).

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUS without ack before abort; legal range 1..65535; counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- wb_clk_i  input  1  system clock; all logic is rising-edge.
- nrst  input  1  asynchronous active-low reset.
- cpu_req_valid  input  1  request present.
- cpu_req_we  input  1  1=write, 0=read.
- cpu_req_adr  input  32  byte address.
- cpu_req_dat  input  32  write data.
- cpu_req_sel  input  4  byte lanes.
- cpu_req_ready  output  1  block can accept a request (high in IDLE).
- cpu_rsp_valid  output  1  one-cycle response pulse.
- cpu_rsp_dat  output  32  read data (0 for writes and errors).
- cpu_rsp_err  output  1  transaction aborted; qualified by cpu_rsp_valid.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte select.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_ack_i  input  1  slave acknowledge.
- wbm_dat_i  input  32  slave read data.

Behaviour:
- Reset (nrst low, asynchronous):
  - State = IDLE; every output 0 except cpu_req_ready = 1.
  - Timeout counter = 0.
  - Reset mid-transaction drops cyc/stb immediately and produces no response.
- States: IDLE and BUS.
- IDLE:
  - cpu_req_ready = 1.
  - On an edge where cpu_req_valid = 1, capture we/adr/dat/sel into the wbm_* output registers and go to BUS.
  - wbm_cyc_o and wbm_stb_o rise in the cycle after acceptance.
  - wbm_ack_i is ignored in IDLE.
- BUS:
  - cpu_req_ready = 0; cyc = stb = 1; we/adr/dat/sel held stable.
  - On an edge with wbm_ack_i = 1:
    - Go to IDLE; cyc and stb drop next cycle.
    - cpu_rsp_valid = 1 for exactly that next cycle.
    - cpu_rsp_dat = wbm_dat_i if read, else 0; cpu_rsp_err = 0.
- Latency: accept at edge N, stb high in cycle N+1. With ack sampled at edge M, cpu_rsp_valid is high in cycle M+1. A single-cycle-ack slave therefore gives accept-to-response of 2 cycles.
- Back-to-back:
  - cpu_req_ready is high in the same cycle as cpu_rsp_valid, so a new request can be accepted then.
  - stb is always low for at least one cycle between transactions.
- Between transactions, wbm_adr/dat/sel/we hold their last captured values. cpu_rsp_dat/err hold until the next response; only cpu_rsp_valid pulses.
- A request that is not accepted (not in IDLE) is not latched; the requester must hold valid.

Optional Feature:
- Macro WBM_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count equals TIMEOUT_CYCLES with no ack on that edge, go to IDLE, drop cyc/stb, and pulse cpu_rsp_valid with cpu_rsp_err = 1 and cpu_rsp_dat = 0.
  - If ack and timeout coincide on the same edge, ack wins: normal response, err = 0.
- Undefined:
  - No counter logic; BUS waits for ack indefinitely.
  - cpu_rsp_err is tied to 0; TIMEOUT_CYCLES is unused.

Decomposition:
- Package wbm_pkg holds:
  - the state enum (WBM_IDLE, WBM_BUS);
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4.
- One natural sub-module, wbm_timeout_counter (clear, enable, limit, expired), instantiated only under WBM_TIMEOUT_EN.
- Everything else stays in the top FSM.

Test Plan:
- Reset values: hold nrst low for 3 cycles, then release → all wbm_* = 0, cpu_req_ready = 1, cpu_rsp_valid = 0. Assert nrst mid-BUS → cyc/stb fall without a clock edge and no rsp follows.
- Single write: we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks 2 cycles after stb → wbm outputs match and hold stable while stb is high; rsp_valid pulses once, 1 cycle after ack, with err=0 and dat=0.
- Single read: adr=0x3000_0010, sel=0x3; slave returns 0x1234_5678 with ack in the first stb cycle → rsp_dat = 0x1234_5678 two cycles after accept; ready low only in the BUS cycle.
- Back-to-back: requester keeps valid high for 4 requests against an immediate-ack slave → 4 responses in order, stb low ≥1 cycle between each, no request dropped or duplicated.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks → after 4 BUS cycles cyc/stb drop and rsp_valid pulses with err=1, dat=0. Repeat with ack on the 4th cycle → err=0, normal data.
- Spurious ack: pulse wbm_ack_i while IDLE → no state change and no rsp_valid.
